// File: rtl/latch_pkg.sv
// latch_pkg: shared states, requester ids and default sizes for the latch bank arbiter
package latch_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/gated_latch.sv
// gated_latch: level-sensitive gated D latch word, transparent while en is high
module gated_latch #(
  parameter int W = 8
) (
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_latch
    if (en) q <= d;
endmodule

// File: rtl/latch_bank.sv
// latch_bank: DEPTH gated latch words on a common D bus with a combinational read mux
module latch_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] en,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [DEPTH-1:0][WIDTH-1:0] word;
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    gated_latch #(.W(WIDTH)) u_word (
      .en(en[i]),
      .d (d),
      .q (word[i])
    );
  end
  assign rd_data = word[rd_addr];
endmodule

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: two-requester round-robin write arbiter and strobe sequencer
// for a gated-latch bank; data is set up one cycle before and held one cycle after the strobe.
module latch_bank_arbiter
  import latch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  data_b,
  output logic              ack_b,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy
);
  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              grant_b;
  logic [DEPTH-1:0]  bank_en;
  // B wins when alone, or on a tie when A was served last
  assign grant_b = req_b && (!req_a || last_q == REQ_A);
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      if (req_a || req_b) begin
        state_d = SETUP;
        id_d    = grant_b ? REQ_B : REQ_A;
        addr_d  = grant_b ? addr_b : addr_a;
        data_d  = grant_b ? data_b : data_a;
      end
    end else begin
      state_d = state_q == SETUP ? STROBE : state_q == STROBE ? HOLD : IDLE;
    end
    if (state_q == HOLD) last_d = id_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      id_q    <= REQ_A;
      last_q  <= REQ_B;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  assign bank_en = state_q == STROBE ? DEPTH'(1) << addr_q : '0;
  assign ack_a   = state_q == HOLD && id_q == REQ_A;
  assign ack_b   = state_q == HOLD && id_q == REQ_B;
  assign busy    = state_q != IDLE;
  latch_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
    .en     (bank_en),
    .d      (data_q),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb_latch_bank_arbiter: scenario tasks plus an ack scoreboard for latch_bank_arbiter
module tb_latch_bank_arbiter;
  import latch_pkg::*;
  logic       clk = 0, rst = 1;
  logic       req_a = 0, req_b = 0, ack_a, ack_b, busy;
  logic [1:0] addr_a = 0, addr_b = 0, rd_addr = 0;
  logic [7:0] data_a = 0, data_b = 0, rd_data;
  int checks = 0, errors = 0;
  typedef struct packed {logic id; logic [1:0] addr; logic [7:0] data;} wr_t;
  wr_t sb[$];
  wr_t mon_e;

  latch_bank_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // every ack must match the oldest expected write; never more than one enable
  always @(negedge clk)
    if (!rst) begin
      checks++;
      if ($countones(dut.bank_en) > 1) begin
        errors++;
        $display("FAIL onehot_en got en=%b want at most one bit set", dut.bank_en);
      end
      if (ack_a || ack_b) begin
        checks++;
        if (sb.size() == 0 || (ack_a && ack_b)) begin
          errors++;
          $display("FAIL unexpected_ack got ack_a=%b ack_b=%b pending=%0d want one expected ack", ack_a, ack_b, sb.size());
        end else begin
          mon_e = sb.pop_front();
          if (ack_b !== mon_e.id || dut.addr_q !== mon_e.addr || dut.data_q !== mon_e.data) begin
            errors++;
            $display("FAIL scoreboard got id=%b addr=%0d data=%h want id=%b addr=%0d data=%h",
                     ack_b, dut.addr_q, dut.data_q, mon_e.id, mon_e.addr, mon_e.data);
          end
        end
      end
    end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1; req_a = 0; req_b = 0;
    tick;
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; req_a = 1; req_b = 1; addr_a = 1; data_a = 8'h5C;
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0 || dut.bank_en !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b ack_a=%b ack_b=%b en=%b want all 0", busy, ack_a, ack_b, dut.bank_en);
    end
    checks++;
    if (dut.addr_q !== 2'd0 || dut.data_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_capture got addr=%0d data=%h want 0/00", dut.addr_q, dut.data_q);
    end
    rst = 0; req_a = 0; req_b = 0;
  endtask

  task automatic test_single_a;
    do_reset;
    addr_a = 2; data_a = 8'hA5; req_a = 1; rd_addr = 2;
    sb.push_back('{REQ_A, 2'd2, 8'hA5});
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (c == 1) begin req_a = 0; data_a = 8'h00; addr_a = 0; end
      checks++;
      if (ack_a !== (c == 3) || ack_b !== 1'b0 || busy !== (c <= 3)) begin
        errors++;
        $display("FAIL single_ctrl c=%0d got ack_a=%b ack_b=%b busy=%b want %b/0/%b", c, ack_a, ack_b, busy, c == 3, c <= 3);
      end
      checks++;
      if (dut.bank_en !== (c == 2 ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL single_en c=%0d got %b want %b", c, dut.bank_en, c == 2 ? 4'b0100 : 4'b0000);
      end
      if (c >= 2) begin
        checks++;
        if (rd_data !== 8'hA5) begin
          errors++;
          $display("FAIL single_rd c=%0d got %h want a5", c, rd_data);
        end
      end
    end
  endtask

  task automatic test_tie;
    do_reset;
    req_a = 1; addr_a = 0; data_a = 8'h11;
    req_b = 1; addr_b = 1; data_b = 8'h22;
    sb.push_back('{REQ_A, 2'd0, 8'h11});
    sb.push_back('{REQ_B, 2'd1, 8'h22});
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 1) req_a = 0;
      checks++;
      if (ack_a !== (c == 3) || ack_b !== (c == 7) || busy !== (c != 4 && c != 8)) begin
        errors++;
        $display("FAIL tie_ctrl c=%0d got ack_a=%b ack_b=%b busy=%b want %b/%b/%b", c, ack_a, ack_b, busy, c == 3, c == 7, c != 4 && c != 8);
      end
      if (c == 7) req_b = 0;
    end
    rd_addr = 0; #1;
    checks++;
    if (rd_data !== 8'h11) begin errors++; $display("FAIL tie_bank0 got %h want 11", rd_data); end
    rd_addr = 1; #1;
    checks++;
    if (rd_data !== 8'h22) begin errors++; $display("FAIL tie_bank1 got %h want 22", rd_data); end
  endtask

  task automatic test_back_to_back_alternate;
    logic last = REQ_B;
    logic win;
    logic [7:0] exp_bank [4];
    for (int g = 0; g < 8; g++) begin
      req_a = 1; addr_a = 2'(g); data_a = 8'hA0 + 8'(g);
      req_b = 1; addr_b = 2'(g); data_b = 8'hB0 + 8'(g);
      win = last == REQ_B ? REQ_A : REQ_B;
      sb.push_back('{win, 2'(g), win == REQ_A ? data_a : data_b});
      exp_bank[g % 4] = win == REQ_A ? data_a : data_b;
      for (int c = 1; c <= 3; c++) begin
        tick;
        checks++;
        if (ack_a !== (c == 3 && win == REQ_A) || ack_b !== (c == 3 && win == REQ_B) || $countones(dut.bank_en) != int'(c == 2)) begin
          errors++;
          $display("FAIL alt g=%0d c=%0d got ack_a=%b ack_b=%b en=%b want winner %b acking at c=3", g, c, ack_a, ack_b, dut.bank_en, win);
        end
      end
      if (win == REQ_A) req_a = 0; else req_b = 0;
      last = win;
      if (g == 7) begin req_a = 0; req_b = 0; end
      tick;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL alt_idle g=%0d got busy=%b want 0", g, busy); end
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++;
      if (rd_data !== exp_bank[i]) begin errors++; $display("FAIL alt_bank%0d got %h want %h", i, rd_data, exp_bank[i]); end
    end
  endtask

  task automatic test_data_change;
    req_b = 1; addr_b = 3; data_b = 8'h33;
    sb.push_back('{REQ_B, 2'd3, 8'h33});
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (c == 1) begin data_b = 8'hFF; addr_b = 0; end
      checks++;
      if (ack_b !== (c == 3) || ack_a !== 1'b0) begin
        errors++;
        $display("FAIL change_ack c=%0d got ack_b=%b ack_a=%b want %b/0", c, ack_b, ack_a, c == 3);
      end
      if (c == 3) req_b = 0;
    end
    rd_addr = 3; #1;
    checks++;
    if (rd_data !== 8'h33) begin errors++; $display("FAIL change_bank3 got %h want 33", rd_data); end
  endtask

  task automatic test_abort;
    req_a = 1; addr_a = 3; data_a = 8'h77;
    sb.push_back('{REQ_A, 2'd3, 8'h77});
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (c == 3) req_a = 0;
    end
    req_a = 1; addr_a = 3; data_a = 8'h99;
    tick;
    req_a = 0;
    tick;
    checks++;
    if (dut.bank_en !== 4'b1000) begin errors++; $display("FAIL abort_strobe got en=%b want 1000", dut.bank_en); end
    rst = 1;
    tick;
    checks++;
    if (busy !== 1'b0 || ack_a !== 1'b0 || dut.bank_en !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle got busy=%b ack_a=%b en=%b want 0/0/0000", busy, ack_a, dut.bank_en);
    end
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (ack_a !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_noack got ack_a=%b busy=%b want 0/0", ack_a, busy); end
    end
    req_a = 1; addr_a = 0; data_a = 8'hC0;
    req_b = 1; addr_b = 1; data_b = 8'hC1;
    sb.push_back('{REQ_A, 2'd0, 8'hC0});
    sb.push_back('{REQ_B, 2'd1, 8'hC1});
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 1) req_a = 0;
      checks++;
      if (ack_a !== (c == 3) || ack_b !== (c == 7)) begin
        errors++;
        $display("FAIL abort_tie c=%0d got ack_a=%b ack_b=%b want %b/%b", c, ack_a, ack_b, c == 3, c == 7);
      end
      if (c == 7) req_b = 0;
    end
  endtask

  task automatic test_repeat;
    req_a = 1; addr_a = 2; data_a = 8'h5A;
    sb.push_back('{REQ_A, 2'd2, 8'h5A});
    for (int c = 1; c <= 8; c++) begin
      tick;
      checks++;
      if (ack_a !== (c == 3 || c == 7) || ack_b !== 1'b0) begin
        errors++;
        $display("FAIL repeat_ack c=%0d got ack_a=%b ack_b=%b want %b/0", c, ack_a, ack_b, c == 3 || c == 7);
      end
      if (c == 3) begin
        addr_a = 1; data_a = 8'hC3;
        sb.push_back('{REQ_A, 2'd1, 8'hC3});
      end
      if (c == 7) req_a = 0;
    end
    rd_addr = 2; #1;
    checks++;
    if (rd_data !== 8'h5A) begin errors++; $display("FAIL repeat_bank2 got %h want 5a", rd_data); end
    rd_addr = 1; #1;
    checks++;
    if (rd_data !== 8'hC3) begin errors++; $display("FAIL repeat_bank1 got %h want c3", rd_data); end
  endtask

  initial begin
    test_reset;
    test_single_a;
    test_tie;
    test_back_to_back_alternate;
    test_data_change;
    test_abort;
    test_repeat;
    tick;
    tick;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d pending want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/latch_bank_arbiter.md
# latch_bank_arbiter

Two-requester round-robin write arbiter and strobe sequencer for a small bank of level-sensitive gated D latches. It sits between two independent writers, such as the switch-input path and the UART byte path on the MAX1000 labs, and the shared latch storage. It serialises their writes and drives each latch enable with guaranteed data setup and hold around a one-cycle strobe. It also provides a combinational read port for LED/7-segment display logic.

## Interface
- WIDTH, 8, data bits per latch word
- DEPTH, 4, number of latch words; must be a power of two, 2..16
- ADDR_W, $clog2(DEPTH), derived, not overridden
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_a  input  1  requester A write request (level)
- addr_a  input  ADDR_W  A target word
- data_a  input  WIDTH  A write data
- ack_a  output  1  one-cycle pulse: A's write complete
- req_b, addr_b, data_b, ack_b  same as A, for requester B
- rd_addr  input  ADDR_W  read select
- rd_data  output  WIDTH  bank[rd_addr], combinational
- busy  output  1  high whenever FSM not in IDLE

## Operation
- FSM states, in order: IDLE → SETUP → STROBE → HOLD → IDLE. Each state lasts exactly one cycle except IDLE.
- IDLE: the arbiter samples req_a/req_b.
  - Only one high: grant it.
  - Both high: grant the requester not granted last. The last_grant flop resets to B, so A wins the first tie.
  - Neither high: stay in IDLE.
- On grant, the block captures addr/data/requester-id into internal registers. Requesters need only be valid in the grant cycle. Later changes to addr/data/req are ignored until HOLD completes.
- SETUP: captured data is driven onto the bank D bus. All enables are 0.
- STROBE: en[captured addr]=1 and all other enables are 0. The addressed latch is transparent.
- HOLD: all enables 0. Data is held on the D bus. ack of the granted requester = 1. last_grant is updated.
- Only one enable is ever high, and only in STROBE. The D bus is stable from SETUP through HOLD.
- A requester must drop req on the edge where it samples ack=1. If req is still high in the following IDLE cycle, it is a new request.
- rd_data is combinational from the bank.
  - If rd_addr equals the written word, rd_data reflects the new data from STROBE onward.
- rst:
  - forces IDLE, all enables 0, ack_a=ack_b=0, busy=0, last_grant=B, captured registers 0.
  - Latch contents are NOT cleared. rd_data is undefined until the word is first written.
- rst during SETUP/STROBE/HOLD aborts the transaction with no ack.
  - An abort in STROBE may leave the target word partially updated. This is accepted.
- Address width: addresses are exactly ADDR_W bits, so there is no out-of-range case.

## Timing
- Cycle 0: IDLE with req high (grant).
- Cycles 1, 2, 3: SETUP, STROBE, HOLD. ack is high in cycle 3 only.
- Cycle 4: IDLE.
- Write latency is 3 cycles from grant to ack. Peak throughput is one write per 4 cycles.
- Both requesting continuously with correct req drop gives alternating A, B, A… grants, each 4 cycles apart.
- Request-to-grant wait is at most 4 cycles for the losing requester of a tie.
- busy is high in cycles 1–3.

## Structure
- Shared package latch_pkg holds:
  - state enum {IDLE, SETUP, STROBE, HOLD}
  - requester-id constants REQ_A=0, REQ_B=1
  - default WIDTH/DEPTH localparams
- Sub-module latch_bank (WIDTH, DEPTH):
  - an array of gated D latch words with per-word en, a common D bus, and a combinational read mux
  - built from the team's existing gated-latch cell
  - the arbiter instantiates one latch_bank

## Test plan
- Reset, then A writes 8'hA5 to addr 2 → ack_a high exactly in cycle 3, en[2] high only in cycle 2, rd_data(rd_addr=2)=8'hA5 from cycle 2. ack_b never asserted.
- A and B request in the same IDLE cycle (A: addr 0/8'h11, B: addr 1/8'h22) after reset → A granted first, B acks 4 cycles after A. bank[0]=8'h11, bank[1]=8'h22.
- Both hold req continuously with correct drops for 8 grants → strict A/B alternation, every ack 4 cycles apart, never two enables high at once.
- B changes data_b from 8'h33 to 8'hFF in cycle 1 after grant → bank stores 8'h33.
- rst asserted in STROBE of A's write to addr 3 → next cycle IDLE, busy=0, no ack_a, all en 0. Next tie grants A (last_grant=B).
- Requester keeps req high one cycle past ack → a second write is performed and acked 4 cycles later.
